addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter: W, 4, operand/result width; any value other than 4 SHALL be an elaboration error.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: req0/req1  input  1  each requester's operation request.
REQ-005 SHALL have ports: op0/op1  input  1  each requester's operation select; 0 = add, 1 = sub (A-B).
REQ-006 SHALL have ports: a0/b0 and a1/b1  input  W  operands A and B per requester.
REQ-007 SHALL have ports: gnt0/gnt1  output  1  one-cycle acceptance pulse per requester.
REQ-008 SHALL have port: res_valid  output  1  result available.
REQ-009 SHALL have port: res_data  output  W  sum or difference, modulo 2^W.
REQ-010 SHALL have port: res_cout  output  1  adder carry-out; for sub, 1 = no borrow (A>=B).
REQ-011 SHALL have port: res_id  output  1  index of the requester that owns the result.
REQ-012 SHALL have port: res_ready  input  1  consumer accepts the result.

Function
REQ-013 SHALL implement states: IDLE, EXEC, HOLD.
REQ-014 In IDLE with any req high at an edge: SHALL select one requester, latch its op/a/b, register a pulse on its gnt and on no other, and enter EXEC.
REQ-015 In IDLE with no req: SHALL remain in IDLE; gnt0/gnt1 low.
REQ-016 In EXEC: SHALL drive the shared adder with the latched operands, register S, Cout and the id into the result registers, assert res_valid, and enter HOLD.
REQ-017 Latency: req sampled at edge k -> gnt high in cycle k+1 -> res_valid high from cycle k+2.
REQ-018 In HOLD: res_valid, res_data, res_cout and res_id SHALL stay stable until res_ready is sampled high; then res_valid SHALL clear and the state SHALL return to IDLE.
REQ-019 Back-to-back throughput: at most one operation per 3 cycles; req SHALL be ignored outside IDLE.
REQ-020 A requester SHALL hold req and its operands until gnt; its operands are don't-care after gnt.
REQ-021 Subtraction SHALL be A + ~B + 1 (carry-in = op); wrap-around modulo 16 with no saturation.
REQ-022 res_ready high while res_valid is low SHALL have no effect.

Reset
REQ-023 When rst is sampled high in any state: SHALL go to IDLE, discard any in-flight operation, clear res_valid, res_data, res_cout, res_id, gnt0 and gnt1 to 0, and reset the arbitration pointer so requester 0 is favoured.

Configuration
REQ-024 With ADDSUB_ARB_RR_EN defined: on simultaneous requests, SHALL grant the requester not granted most recently (round-robin); the pointer updates on each grant.
REQ-025 Without ADDSUB_ARB_RR_EN: SHALL use fixed priority, with req0 always winning over req1; no pointer state exists.

Structure
REQ-026 A shared package (addsub_arb_pkg) SHALL hold the state enum typedef, the W=4 constant and the OP_ADD/OP_SUB constants.
REQ-027 SHALL instantiate exactly one 4-bit ripple add/sub adder as its sub-module, with the inversion of B and carry-in driven from the latched op; no other arithmetic in the block.

Verification
REQ-028 Reset test: assert rst in HOLD with res_valid=1 -> next cycle state is IDLE and all outputs are 0.
REQ-029 Add test: req0, op0=0, a0=5, b0=3 -> gnt0 pulse at k+1; res_data=8, res_cout=0, res_id=0 at k+2.
REQ-030 Subtract tests: req1, op1=1, a1=5, b1=3 -> res_data=2, res_cout=1; then a1=3, b1=5 -> res_data=14, res_cout=0, res_id=1.
REQ-031 Overflow test: a0=9, b0=9, add -> res_data=2, res_cout=1; hold res_ready=0 for 5 cycles -> outputs stable and no new gnt.
REQ-032 Contention test: req0 and req1 held high continuously with res_ready=1 -> grants alternate 0,1,0,1 with RR_EN defined, and are always gnt0 without it.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the add/sub arbiter: FSM state encoding,
// datapath width and operation select codes.
package addsub_arb_pkg;

    localparam int DATA_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_arbiter_adder.sv
// Ripple-carry add/sub unit: sub=1 computes a + ~b + 1, so cout=1 means no borrow.
module addsub_arbiter_adder
    import addsub_arb_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0]   carry;
    logic [W-1:0] b_eff;

    assign carry[0] = sub;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_bit
            assign b_eff[i]     = b[i] ^ sub;
            assign sum[i]       = a[i] ^ b_eff[i] ^ carry[i];
            assign carry[i+1]   = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    endgenerate

    assign cout = carry[W];

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one add/sub unit: IDLE -> EXEC -> HOLD per operation.
// Define ADDSUB_ARB_RR_EN for round-robin on contention; default is fixed priority to req0.
module addsub_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic         op0,
    input  logic         op1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_cout,
    output logic         res_id,
    input  logic         res_ready
);

    generate
        if (W != DATA_W) begin : g_width_check
            $error("addsub_arbiter: W must be 4");
        end
    endgenerate

    state_t       state;
    logic         lat_op;
    logic [W-1:0] lat_a;
    logic [W-1:0] lat_b;
    logic         lat_id;
    logic         sel_id;
    logic [W-1:0] sum;
    logic         cout;

`ifdef ADDSUB_ARB_RR_EN
    // last_id resets to 1 so that requester 0 wins the first contention
    logic last_id;
    assign sel_id = (req0 && req1) ? ~last_id : req1;
`else
    assign sel_id = ~req0;
`endif

    addsub_arbiter_adder #(.W(W)) u_adder (
        .a    (lat_a),
        .b    (lat_b),
        .sub  (lat_op == OP_SUB),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
            lat_op    <= OP_ADD;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_id    <= 1'b0;
`ifdef ADDSUB_ARB_RR_EN
            last_id   <= 1'b1;
`endif
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        lat_id  <= sel_id;
                        lat_op  <= sel_id ? op1 : op0;
                        lat_a   <= sel_id ? a1 : a0;
                        lat_b   <= sel_id ? b1 : b0;
                        gnt0    <= ~sel_id;
                        gnt1    <= sel_id;
`ifdef ADDSUB_ARB_RR_EN
                        last_id <= sel_id;
`endif
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= sum;
                    res_cout  <= cout;
                    res_id    <= lat_id;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter: vector table plus reset,
// hold/backpressure and contention sequences.
module tb_addsub_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_cout;
    logic       res_id;
    logic       res_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       req_id;
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_data;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    addsub_arbiter #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction from a single requester; operands are scrambled after gnt
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        res_ready = 1'b0;
        req0 = (v.req_id == 1'b0);
        req1 = (v.req_id == 1'b1);
        op0 = v.op; a0 = v.a; b0 = v.b;
        op1 = v.op; a1 = v.a; b1 = v.b;
        @(posedge clk); #1;
        check_output("vec_gnt0", gnt0, (v.req_id == 1'b0));
        check_output("vec_gnt1", gnt1, (v.req_id == 1'b1));
        check_output("vec_valid_early", res_valid, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
        op0 = ~v.op; op1 = ~v.op;
        @(posedge clk); #1;
        check_output("vec_valid", res_valid, 1'b1);
        check_output("vec_data", res_data, v.exp_data);
        check_output("vec_cout", res_cout, v.exp_cout);
        check_output("vec_id", res_id, v.req_id);
        check_output("vec_no_gnt", {gnt0, gnt1}, 2'b00);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check_output("vec_valid_clear", res_valid, 1'b0);
        res_ready = 1'b0;
    endtask

    initial begin
        int cycles;
        logic exp_id;

        vecs[0] = '{1'b0, 1'b0, 4'd5,  4'd3, 4'd8,  1'b0};
        vecs[1] = '{1'b1, 1'b1, 4'd5,  4'd3, 4'd2,  1'b1};
        vecs[2] = '{1'b1, 1'b1, 4'd3,  4'd5, 4'd14, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'd9,  4'd9, 4'd2,  1'b1};
        vecs[4] = '{1'b0, 1'b1, 4'd0,  4'd0, 4'd0,  1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'd15, 4'd1, 4'd0,  1'b1};
        vecs[6] = '{1'b0, 1'b1, 4'd7,  4'd8, 4'd15, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 4'd6,  4'd7, 4'd13, 1'b0};

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_outputs", {gnt0, gnt1, res_valid, res_cout, res_id, res_data}, 9'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Overflow result held under backpressure; requests during HOLD are ignored
        @(negedge clk);
        req0 = 1'b1; op0 = 1'b0; a0 = 4'd9; b0 = 4'd9;
        @(posedge clk); #1;
        check_output("hold_gnt0", {gnt0, gnt1}, 2'b10);
        req1 = 1'b1; op1 = 1'b1; a1 = 4'd1; b1 = 4'd1;
        @(posedge clk); #1;
        check_output("hold_valid", res_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_output("hold_stable", {res_valid, res_cout, res_id, res_data}, {1'b1, 1'b1, 1'b0, 4'd2});
            check_output("hold_no_gnt", {gnt0, gnt1}, 2'b00);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        check_output("hold_release", res_valid, 1'b0);
        res_ready = 1'b0;

        // Reset while holding a result owned by requester 0
        @(negedge clk);
        req0 = 1'b1; op0 = 1'b0; a0 = 4'd9; b0 = 4'd9;
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        check_output("prerst_valid", res_valid, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("hold_rst_outputs", {gnt0, gnt1, res_valid, res_cout, res_id, res_data}, 9'h0);

        // Contention: both requesters always asserting, consumer always ready
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; op0 = 1'b0; a0 = 4'd1; b0 = 4'd2;
        req1 = 1'b1; op1 = 1'b1; a1 = 4'd7; b1 = 4'd2;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycles = 0;
            do begin
                @(posedge clk); #1;
                cycles++;
            end while (!(gnt0 || gnt1) && cycles < 8);
            check_output("cont_gap", 8'(cycles), (i == 0) ? 8'd1 : 8'd3);
`ifdef ADDSUB_ARB_RR_EN
            exp_id = 1'(i % 2);
`else
            exp_id = 1'b0;
`endif
            check_output("cont_grant", {gnt0, gnt1}, exp_id ? 2'b01 : 2'b10);
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
